// File: rtl/sender_if.sv
// Event-sender bus: event request/flags in, 4-phase ack in, dual-rail data out.
interface sender_if;
  logic go;
  logic Ch1;
  logic Ch2;
  logic Up;
  logic Down;
  logic ack;
  logic bit0;
  logic bit1;

  modport master (
    output go, Ch1, Ch2, Up, Down, ack,
    input  bit0, bit1
  );

  modport slave (
    input  go, Ch1, Ch2, Up, Down, ack,
    output bit0, bit1
  );
endinterface

// File: rtl/sender.sv
// Dual-rail event sender: latches {Ch1,Ch2,Up,Down} on a go rising edge and ships it
// MSB first, one bit per 4-phase return-to-zero handshake on ack.
module sender #(
  parameter int unsigned FRAME_BITS  = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input logic     clk,
  input logic     reset,
  sender_if.slave bus
);

  localparam int unsigned CntW = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(FRAME_BITS - 1);

  typedef enum logic [1:0] {StIdle, StData, StRtz} state_e;

  state_e                  state_q, state_d;
  logic [SYNC_STAGES-1:0]  go_sync_q, ack_sync_q, vld_sync_q;
  logic                    go_prev_q, armed_q, armed_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic [FRAME_BITS-1:0]   frame_q, frame_d, frame_load, frame_next;
  logic                    bit0_q, bit0_d, bit1_q, bit1_d;
  logic                    go_s, ack_s, vld_s, start;
  logic [3:0]              flags;

  assign go_s  = go_sync_q[SYNC_STAGES-1];
  assign ack_s = ack_sync_q[SYNC_STAGES-1];
  // vld_s marks when go_s carries a real sample rather than the reset fill.
  assign vld_s = vld_sync_q[SYNC_STAGES-1];
  // armed_q requires a genuine low go after reset, so a go held high never starts a frame.
  assign start = armed_q & go_s & ~go_prev_q;
  assign flags = {bus.Ch1, bus.Ch2, bus.Up, bus.Down};

  // Flags land in the top frame bits; any extra low bits go out as logical 0.
  assign frame_load = FRAME_BITS'({flags, 32'd0} >> (36 - FRAME_BITS));
  assign frame_next = frame_q << (cnt_q + 1'b1);

  assign bus.bit0 = bit0_q;
  assign bus.bit1 = bit1_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      go_sync_q  <= '0;
      ack_sync_q <= '0;
      vld_sync_q <= '0;
      go_prev_q  <= 1'b0;
      armed_q    <= 1'b0;
      state_q    <= StIdle;
      cnt_q      <= '0;
      frame_q    <= '0;
      bit0_q     <= 1'b0;
      bit1_q     <= 1'b0;
    end else begin
      go_sync_q  <= (go_sync_q << 1) | SYNC_STAGES'(bus.go);
      ack_sync_q <= (ack_sync_q << 1) | SYNC_STAGES'(bus.ack);
      vld_sync_q <= (vld_sync_q << 1) | SYNC_STAGES'(1'b1);
      go_prev_q  <= go_s;
      armed_q    <= armed_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      frame_q    <= frame_d;
      bit0_q     <= bit0_d;
      bit1_q     <= bit1_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    frame_d = frame_q;
    bit0_d  = bit0_q;
    bit1_d  = bit1_q;
    armed_d = armed_q | (vld_s & ~go_s);

    case (state_q)
      StIdle: begin
        if (start) begin
          frame_d = frame_load;
          cnt_d   = '0;
          if (flags != 4'd0) begin
            state_d = StData;
            bit1_d  = frame_load[FRAME_BITS-1];
            bit0_d  = ~frame_load[FRAME_BITS-1];
          end
        end
      end
      StData: begin
        if (ack_s) begin
          bit0_d  = 1'b0;
          bit1_d  = 1'b0;
          state_d = StRtz;
        end
      end
      StRtz: begin
        if (!ack_s) begin
          if (cnt_q == LastCnt) begin
            cnt_d   = '0;
            state_d = StIdle;
          end else begin
            cnt_d   = cnt_q + 1'b1;
            bit1_d  = frame_next[FRAME_BITS-1];
            bit0_d  = ~frame_next[FRAME_BITS-1];
            state_d = StData;
          end
        end
      end
      default: begin
        state_d = StIdle;
        bit0_d  = 1'b0;
        bit1_d  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_sender.sv
// Scoreboard bench for sender: expected rail symbols are queued when a frame is launched
// and popped whenever a rail rises out of a spacer.
module tb_sender;
  localparam int unsigned FrameBits  = 4;
  localparam int unsigned SyncStages = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sender_if sif ();

  sender #(
    .FRAME_BITS (FrameBits),
    .SYNC_STAGES(SyncStages)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (sif)
  );

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;
  logic [1:0]  exp_q[$];
  logic [1:0]  prev_rails = 2'b00;
  logic [1:0]  mon_rails;
  logic [1:0]  mon_exp;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // 2'b10 = logical 1 on bit1, 2'b01 = logical 0 on bit0.
  always @(negedge clk) begin
    mon_rails = {sif.bit1, sif.bit0};
    check("onehot", int'(sif.bit0 & sif.bit1), 0);
    if (mon_rails != 2'b00 && prev_rails == 2'b00) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rail", int'(mon_rails), 0);
      end else begin
        mon_exp = exp_q.pop_front();
        check("rail", int'(mon_rails), int'(mon_exp));
      end
    end
    prev_rails = mon_rails;
  end

  task automatic wait_rails(input logic want_hi, input string tag);
    int n = 0;
    while (((sif.bit0 | sif.bit1) != want_hi) && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) check({tag, "_timeout"}, 0, 1);
  endtask

  task automatic recv(input int n);
    for (int k = 0; k < n; k++) begin
      wait_rails(1'b1, "rail_hi");
      @(negedge clk) sif.ack = 1'b1;
      wait_rails(1'b0, "rail_lo");
      @(negedge clk) sif.ack = 1'b0;
      repeat (3) @(negedge clk);
    end
  endtask

  task automatic ack_pulses(input int n, input string tag);
    for (int k = 0; k < n; k++) begin
      @(negedge clk) sif.ack = 1'b1;
      repeat (4) @(negedge clk);
      check(tag, int'({sif.bit1, sif.bit0}), 0);
      sif.ack = 1'b0;
      repeat (4) @(negedge clk);
    end
  endtask

  // Leaves go high; caller decides when to drop it.
  task automatic send_frame(input logic [3:0] f);
    int lat = 0;
    {sif.Ch1, sif.Ch2, sif.Up, sif.Down} = f;
    if (f != 4'd0) begin
      for (int i = 3; i >= 0; i--) exp_q.push_back(f[i] ? 2'b10 : 2'b01);
    end
    @(negedge clk) sif.go = 1'b1;
    if (f != 4'd0) begin
      while ((sif.bit0 | sif.bit1) == 1'b0 && lat < 20) begin
        @(negedge clk);
        lat++;
      end
      check("go_latency_ok", int'(lat <= int'(SyncStages) + 2), 1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset  = 1'b0;
    sif.go = 1'b0;
    sif.ack = 1'b0;
    {sif.Ch1, sif.Ch2, sif.Up, sif.Down} = 4'd0;
    repeat (3) @(negedge clk);
    check("rst_bit0", int'(sif.bit0), 0);
    check("rst_bit1", int'(sif.bit1), 0);
    @(negedge clk) reset = 1'b1;
    repeat (4) @(negedge clk);

    // Ch2/Down frame: 0,1,0,1.
    send_frame(4'b0101);
    repeat (2) @(negedge clk);
    sif.go = 1'b0;
    recv(4);
    repeat (4) @(negedge clk);
    check("t1_idle_rails", int'({sif.bit1, sif.bit0}), 0);
    check("t1_sb_empty", exp_q.size(), 0);

    // Stray acks in idle.
    ack_pulses(18, "t2_quiet");

    // Ch1/Up with go held high: one frame only until go re-rises.
    send_frame(4'b1010);
    recv(4);
    ack_pulses(5, "t3_no_retrigger");
    check("t3_sb_empty", exp_q.size(), 0);
    sif.go = 1'b0;
    repeat (5) @(negedge clk);
    send_frame(4'b1010);
    {sif.Ch1, sif.Ch2, sif.Up, sif.Down} = 4'b0111;  // must not disturb the latched frame
    @(negedge clk) sif.go = 1'b0;
    @(negedge clk) sif.go = 1'b1;
    recv(4);
    sif.go = 1'b0;
    repeat (4) @(negedge clk);
    check("t3_sb_empty2", exp_q.size(), 0);

    // All flags zero: nothing ever goes out.
    send_frame(4'b0000);
    repeat (3) @(negedge clk);
    sif.go = 1'b0;
    repeat (20) @(negedge clk);
    ack_pulses(3, "t4_quiet");

    // Reset during the second DATA phase, with go held high across release.
    repeat (4) @(negedge clk);
    send_frame(4'b1001);
    repeat (2) @(negedge clk);
    sif.go = 1'b0;
    recv(1);
    wait_rails(1'b1, "t5_second_rail");
    #2 reset = 1'b0;
    #1;
    check("abort_bit0", int'(sif.bit0), 0);
    check("abort_bit1", int'(sif.bit1), 0);
    exp_q.delete();
    sif.go = 1'b1;
    repeat (3) @(negedge clk);
    @(negedge clk) reset = 1'b1;
    ack_pulses(4, "t5_quiet");
    repeat (10) @(negedge clk);
    check("t5_no_start", int'({sif.bit1, sif.bit0}), 0);
    sif.go = 1'b0;
    repeat (5) @(negedge clk);
    send_frame(4'b0011);
    repeat (2) @(negedge clk);
    sif.go = 1'b0;
    recv(4);
    repeat (4) @(negedge clk);
    check("t5_sb_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/sender.md
SENDER -- requirements
Module: sender

Interface
REQ-001 SHALL have ports: clk  input  1  system clock, all state updates on rising edge.
REQ-002 SHALL have ports: reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-003 SHALL have ports: go  input  1  event request; a rising edge starts one frame.
REQ-004 SHALL have ports: Ch1  input  1  event address flag, channel 1.
REQ-005 SHALL have ports: Ch2  input  1  event address flag, channel 2.
REQ-006 SHALL have ports: Up  input  1  event polarity flag, up.
REQ-007 SHALL have ports: Down  input  1  event polarity flag, down.
REQ-008 SHALL have ports: ack  input  1  receiver acknowledge, 4-phase return-to-zero.
REQ-009 SHALL have ports: bit0  output  1  dual-rail "logical 0" rail.
REQ-010 SHALL have ports: bit1  output  1  dual-rail "logical 1" rail.
REQ-011 One clock; reset is asynchronous and active-low.
REQ-012 Parameter FRAME_BITS, default 4, frame length in bits.
REQ-013 Parameter SYNC_STAGES, default 2, synchronizer depth for go and ack.

Function
REQ-014 go and ack SHALL each pass through a SYNC_STAGES flip-flop synchronizer before use; Ch1/Ch2/Up/Down are treated as stable while go is high.
REQ-015 A start SHALL be detected on a 0->1 transition of synchronized go while in IDLE; go held high SHALL NOT retrigger.
REQ-016 On start, frame register SHALL latch {Ch1, Ch2, Up, Down} (bit 3 = Ch1 ... bit 0 = Down).
REQ-017 On start with all four flags 0, no frame SHALL be sent; the block stays in IDLE.
REQ-018 Bits SHALL be sent MSB first, one bit per 4-phase handshake.
REQ-019 Encoding: logical 1 = bit1 high, bit0 low; logical 0 = bit0 high, bit1 low; spacer = both low.
REQ-020 bit0 and bit1 SHALL never be high simultaneously, and SHALL be registered outputs.
REQ-021 States: IDLE, DATA, RTZ.
REQ-022 IDLE -> DATA on a valid start; the first bit's rail is driven high on the next clock edge.
REQ-023 DATA: hold the rail; when synchronized ack = 1, drive both rails low on the next edge -> RTZ.
REQ-024 RTZ: wait for synchronized ack = 0; then if bits remain, drive the next bit's rail on the next edge -> DATA, else -> IDLE.
REQ-025 Bit counter SHALL count 0..FRAME_BITS-1 with no wrap; a frame is exactly FRAME_BITS handshakes.
REQ-026 ack transitions in IDLE SHALL be ignored; no output change.
REQ-027 A go edge or any flag change during DATA/RTZ SHALL be ignored; the latched frame is unaffected.
REQ-028 If ack is already high on entry to DATA, it SHALL be treated as the acknowledge (no extra wait).
REQ-029 Worst-case latency: go rise to first rail high SHALL be at most SYNC_STAGES+2 cycles; ack edge to rail response at most SYNC_STAGES+1 cycles.

Reset
REQ-030 While reset = 0: bit0 = 0, bit1 = 0, state = IDLE, counter = 0, frame register = 0, synchronizers = 0, asynchronously.
REQ-031 Reset asserted mid-frame SHALL abort the frame immediately; after release, a new go rising edge is required.
REQ-032 A go already high at reset release SHALL NOT start a frame until it goes low and high again.

Verification
REQ-033 Ch2=1, Down=1, go pulse, then 4 ack high/low cycles -> rails bit0, bit1, bit0, bit1 in order, spacer between each, ending in IDLE with both low.
REQ-034 After REQ-033, 18 further ack pulses with go=0 -> bit0 = bit1 = 0 throughout.
REQ-035 Ch1=Up=1, go held high across the frame and beyond -> frame 1,0,1,0 sent once only; no retrigger until go falls and rises.
REQ-036 go rising with all flags 0 -> no rail ever asserted.
REQ-037 reset=0 during the second DATA phase -> both rails low within the same cycle; after release, ack pulses produce no output.
REQ-038 Every cycle of every test: assertion that bit0 & bit1 == 0.
